// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline control slice: opcodes, ALU-op
// encodings, the per-instruction control bundle and the bubble constant.
package pipe_ctrl_pkg;

    // Major opcodes recognised by the decoder (instr[6:0])
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // ALU-op encodings handed to the ALU control stage
    typedef enum logic [1:0] {
        ALU_ADD    = 2'b00,
        ALU_BRANCH = 2'b01,
        ALU_RFUNC  = 2'b10,
        ALU_IFUNC  = 2'b11
    } aluop_e;

    // Control bundle produced by the decoder and carried in ID/EX
    typedef struct packed {
        logic       regwrite;
        logic       alusrc;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
        logic       branch;
        logic       jump;
        logic [1:0] aluop;
    } ctrl_t;

    // A bubble carries no side effects at all
    localparam ctrl_t CTRL_BUBBLE = '0;

    // True for formats that read rs2 as a register operand
    function automatic logic uses_rs2(input logic [6:0] opcode);
        return (opcode == OP_RTYPE) || (opcode == OP_STORE) || (opcode == OP_BRANCH);
    endfunction

endpackage

// File: rtl/pipe_control_if.sv
// Bundle of the ID-side request signals and the registered control outputs
// of pipe_control. The master side is the pipeline datapath, the slave
// side is pipe_control itself.
interface pipe_control_if #(
    parameter int ALUOP_W   = 2,
    parameter int ILL_CNT_W = 8
);
    // Requests from the ID stage
    logic [31:0]          instr_i;
    logic                 id_valid_i;
    logic                 stall_i;
    logic                 flush_i;

    // Hazard indication and ID/EX control register
    logic                 hazard_o;
    logic                 ex_valid_o;
    logic                 ex_regwrite_o;
    logic                 ex_memread_o;
    logic                 ex_memwrite_o;
    logic                 ex_memtoreg_o;
    logic                 ex_branch_o;
    logic                 ex_alusrc_o;
    logic                 ex_jump_o;
    logic [ALUOP_W-1:0]   ex_aluop_o;
    logic [4:0]           ex_rd_o;

    // EX/MEM control register
    logic                 mem_valid_o;
    logic                 mem_regwrite_o;
    logic                 mem_memread_o;
    logic                 mem_memwrite_o;
    logic                 mem_memtoreg_o;
    logic [4:0]           mem_rd_o;

    // Illegal-instruction reporting
    logic                 illegal_o;
    logic [ILL_CNT_W-1:0] ill_cnt_o;

    modport master (
        output instr_i, id_valid_i, stall_i, flush_i,
        input  hazard_o,
        input  ex_valid_o, ex_regwrite_o, ex_memread_o, ex_memwrite_o,
        input  ex_memtoreg_o, ex_branch_o, ex_alusrc_o, ex_jump_o,
        input  ex_aluop_o, ex_rd_o,
        input  mem_valid_o, mem_regwrite_o, mem_memread_o, mem_memwrite_o,
        input  mem_memtoreg_o, mem_rd_o,
        input  illegal_o, ill_cnt_o
    );

    modport slave (
        input  instr_i, id_valid_i, stall_i, flush_i,
        output hazard_o,
        output ex_valid_o, ex_regwrite_o, ex_memread_o, ex_memwrite_o,
        output ex_memtoreg_o, ex_branch_o, ex_alusrc_o, ex_jump_o,
        output ex_aluop_o, ex_rd_o,
        output mem_valid_o, mem_regwrite_o, mem_memread_o, mem_memwrite_o,
        output mem_memtoreg_o, mem_rd_o,
        output illegal_o, ill_cnt_o
    );

endinterface

// File: rtl/ctrl_decode.sv
// Combinational main-opcode decoder: opcode -> control bundle + illegal flag.
// Define PIPE_CONTROL_JUMP_EN to decode jal/jalr; otherwise they are illegal.
module ctrl_decode
    import pipe_ctrl_pkg::*;
(
    input  logic [6:0] i_opcode,
    output ctrl_t      o_ctrl,
    output logic       o_illegal
);

    // Opcode lookup; anything unrecognised decodes to a bubble and flags illegal
    always_comb begin
        // NOTE: every output gets a default before the case so no path can infer a latch.
        o_ctrl    = CTRL_BUBBLE;
        o_illegal = 1'b0;
        case (i_opcode)
            OP_RTYPE: begin
                o_ctrl.regwrite = 1'b1;
                o_ctrl.aluop    = ALU_RFUNC;
            end
            OP_LOAD: begin
                o_ctrl.regwrite = 1'b1;
                o_ctrl.alusrc   = 1'b1;
                o_ctrl.memread  = 1'b1;
                o_ctrl.memtoreg = 1'b1;
                o_ctrl.aluop    = ALU_ADD;
            end
            OP_STORE: begin
                o_ctrl.alusrc   = 1'b1;
                o_ctrl.memwrite = 1'b1;
                o_ctrl.aluop    = ALU_ADD;
            end
            OP_BRANCH: begin
                o_ctrl.branch   = 1'b1;
                o_ctrl.aluop    = ALU_BRANCH;
            end
            OP_IMM: begin
                o_ctrl.regwrite = 1'b1;
                o_ctrl.alusrc   = 1'b1;
                o_ctrl.aluop    = ALU_IFUNC;
            end
`ifdef PIPE_CONTROL_JUMP_EN
            OP_JAL: begin
                o_ctrl.regwrite = 1'b1;
                o_ctrl.jump     = 1'b1;
                o_ctrl.aluop    = ALU_ADD;
            end
            OP_JALR: begin
                o_ctrl.regwrite = 1'b1;
                o_ctrl.alusrc   = 1'b1;
                o_ctrl.jump     = 1'b1;
                o_ctrl.aluop    = ALU_ADD;
            end
`endif
            default: begin
                o_illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/pipe_control.sv
// Pipeline control slice: decodes the ID instruction, detects load-use
// hazards, and carries control bits through the ID/EX and EX/MEM registers.
// Also reports and counts (saturating) accepted illegal opcodes.
// Optional: define PIPE_CONTROL_JUMP_EN to enable jal/jalr decode; without
// it ex_jump_o is tied low and jal/jalr are illegal.
module pipe_control
    import pipe_ctrl_pkg::*;
#(
    parameter int ALUOP_W   = 2,
    parameter int ILL_CNT_W = 8
) (
    input  logic           clk_i,
    input  logic           rst_i,
    pipe_control_if.slave  bus
);

    // ID-stage instruction fields
    logic [6:0] w_opcode;
    logic [4:0] w_rd;
    logic [4:0] w_rs1;
    logic [4:0] w_rs2;
    logic       w_unused_instr_bits;

    assign w_opcode            = bus.instr_i[6:0];
    assign w_rd                = bus.instr_i[11:7];
    assign w_rs1               = bus.instr_i[19:15];
    assign w_rs2               = bus.instr_i[24:20];
    assign w_unused_instr_bits = ^{bus.instr_i[31:25], bus.instr_i[14:12]};

    // Decoder
    ctrl_t w_dec_ctrl;
    logic  w_dec_illegal;

    ctrl_decode u_decode (
        .i_opcode  (w_opcode),
        .o_ctrl    (w_dec_ctrl),
        .o_illegal (w_dec_illegal)
    );

    // ID/EX and EX/MEM state
    logic                 r_ex_valid;
    ctrl_t                r_ex_ctrl;
    logic [4:0]           r_ex_rd;
    logic                 r_mem_valid;
    logic                 r_mem_regwrite;
    logic                 r_mem_memread;
    logic                 r_mem_memwrite;
    logic                 r_mem_memtoreg;
    logic [4:0]           r_mem_rd;
    logic                 r_illegal;
    logic [ILL_CNT_W-1:0] r_ill_cnt;

    logic w_hazard;
    logic w_accept;

    // Load-use hazard: the load in EX writes a register the ID instruction reads
    always_comb begin
        w_hazard = bus.id_valid_i & r_ex_valid & r_ex_ctrl.memread & (r_ex_rd != 5'd0)
                 & ((r_ex_rd == w_rs1) | ((r_ex_rd == w_rs2) & uses_rs2(w_opcode)))
                 & ~bus.flush_i;
    end

    // An instruction is accepted only when it actually enters EX
    assign w_accept = bus.id_valid_i & ~bus.flush_i & ~bus.stall_i & ~w_hazard;

    // ID/EX register: reset > flush > stall > hazard bubble > normal load
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst_i) begin
            r_ex_valid <= 1'b0;
            r_ex_ctrl  <= CTRL_BUBBLE;
            r_ex_rd    <= 5'd0;
        end else if (bus.flush_i) begin
            r_ex_valid <= 1'b0;
            r_ex_ctrl  <= CTRL_BUBBLE;
            r_ex_rd    <= 5'd0;
        end else if (!bus.stall_i) begin
            if (w_hazard || !bus.id_valid_i) begin
                r_ex_valid <= 1'b0;
                r_ex_ctrl  <= CTRL_BUBBLE;
                r_ex_rd    <= 5'd0;
            end else begin
                r_ex_valid <= 1'b1;
                r_ex_ctrl  <= w_dec_ctrl;
                r_ex_rd    <= w_rd;
            end
        end
    end

    // EX/MEM register: follows ID/EX unless stalled; flush does not reach it
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_mem_valid    <= 1'b0;
            r_mem_regwrite <= 1'b0;
            r_mem_memread  <= 1'b0;
            r_mem_memwrite <= 1'b0;
            r_mem_memtoreg <= 1'b0;
            r_mem_rd       <= 5'd0;
        end else if (!bus.stall_i) begin
            r_mem_valid    <= r_ex_valid;
            r_mem_regwrite <= r_ex_ctrl.regwrite;
            r_mem_memread  <= r_ex_ctrl.memread;
            r_mem_memwrite <= r_ex_ctrl.memwrite;
            r_mem_memtoreg <= r_ex_ctrl.memtoreg;
            r_mem_rd       <= r_ex_rd;
        end
    end

    // Illegal-opcode pulse and saturating counter, driven by accepted instructions only
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_illegal <= 1'b0;
            r_ill_cnt <= '0;
        end else begin
            r_illegal <= w_accept & w_dec_illegal;
            if (w_accept && w_dec_illegal && (r_ill_cnt != '1)) begin
                r_ill_cnt <= r_ill_cnt + ILL_CNT_W'(1);
            end
        end
    end

    // ALU-op zero-padded to the configured output width
    logic [ALUOP_W-1:0] w_ex_aluop;

    always_comb begin
        w_ex_aluop      = '0;
        w_ex_aluop[1:0] = r_ex_ctrl.aluop;
    end

    assign bus.hazard_o       = w_hazard;
    assign bus.ex_valid_o     = r_ex_valid;
    assign bus.ex_regwrite_o  = r_ex_ctrl.regwrite;
    assign bus.ex_memread_o   = r_ex_ctrl.memread;
    assign bus.ex_memwrite_o  = r_ex_ctrl.memwrite;
    assign bus.ex_memtoreg_o  = r_ex_ctrl.memtoreg;
    assign bus.ex_branch_o    = r_ex_ctrl.branch;
    assign bus.ex_alusrc_o    = r_ex_ctrl.alusrc;
`ifdef PIPE_CONTROL_JUMP_EN
    assign bus.ex_jump_o      = r_ex_ctrl.jump;
`else
    assign bus.ex_jump_o      = 1'b0;
`endif
    assign bus.ex_aluop_o     = w_ex_aluop;
    assign bus.ex_rd_o        = r_ex_rd;
    assign bus.mem_valid_o    = r_mem_valid;
    assign bus.mem_regwrite_o = r_mem_regwrite;
    assign bus.mem_memread_o  = r_mem_memread;
    assign bus.mem_memwrite_o = r_mem_memwrite;
    assign bus.mem_memtoreg_o = r_mem_memtoreg;
    assign bus.mem_rd_o       = r_mem_rd;
    assign bus.illegal_o      = r_illegal;
    assign bus.ill_cnt_o      = r_ill_cnt;

endmodule

// File: tb/tb_pipe_control.sv
// Self-checking bench for pipe_control: a stage-level reference model
// (decode table, hazard rule, priority rules, saturating count) checked on
// every cycle, plus directed scenarios with hand-computed expectations.
// Honours PIPE_CONTROL_JUMP_EN the same way the design does.
module tb_pipe_control;

    localparam int ALUOP_W   = 2;
    localparam int ILL_CNT_W = 8;
    localparam int CNT_MAX   = (1 << ILL_CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    pipe_control_if #(.ALUOP_W(ALUOP_W), .ILL_CNT_W(ILL_CNT_W)) bus ();

    pipe_control #(.ALUOP_W(ALUOP_W), .ILL_CNT_W(ILL_CNT_W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int tests_run = 0;
    int tests_failed = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Table row: {illegal, regwrite, alusrc, memread, memwrite, memtoreg, branch, jump, aluop[1:0]}
    function automatic bit [9:0] spec_row(input bit [6:0] opc);
        case (opc)
            7'b0110011: return 10'b0_1000000_10;
            7'b0000011: return 10'b0_1110100_00;
            7'b0100011: return 10'b0_0101000_00;
            7'b1100011: return 10'b0_0000010_01;
            7'b0010011: return 10'b0_1100000_11;
`ifdef PIPE_CONTROL_JUMP_EN
            7'b1101111: return 10'b0_1000001_00;
            7'b1100111: return 10'b0_1100001_00;
`endif
            default:    return 10'b1_0000000_00;
        endcase
    endfunction

    // Model stage contents
    bit       m_ex_v;
    bit [8:0] m_ex_c;   // {rw, as, mr, mw, mtr, br, jmp, aluop}
    bit [4:0] m_ex_rd;
    bit       m_mem_v, m_mem_rw, m_mem_mr, m_mem_mw, m_mem_mtr;
    bit [4:0] m_mem_rd;
    bit       m_ill;
    int       m_cnt;

    function automatic bit model_hazard();
        bit [6:0] opc;
        bit [4:0] rs1, rs2;
        bit reads_rs2;
        opc = bus.instr_i[6:0];
        rs1 = bus.instr_i[19:15];
        rs2 = bus.instr_i[24:20];
        reads_rs2 = (opc == 7'b0110011) || (opc == 7'b0100011) || (opc == 7'b1100011);
        return bus.id_valid_i && m_ex_v && m_ex_c[6] && (m_ex_rd != 0) &&
               ((m_ex_rd == rs1) || (m_ex_rd == rs2 && reads_rs2)) && !bus.flush_i;
    endfunction

    always @(posedge clk) begin
        bit hz;
        bit [9:0] row;
        bit acc;
        hz  = model_hazard();
        row = spec_row(bus.instr_i[6:0]);
        if (rst) begin
            m_ex_v = 0; m_ex_c = '0; m_ex_rd = '0;
            m_mem_v = 0; m_mem_rw = 0; m_mem_mr = 0; m_mem_mw = 0; m_mem_mtr = 0; m_mem_rd = '0;
            m_ill = 0; m_cnt = 0;
        end else begin
            acc = bus.id_valid_i && !bus.flush_i && !bus.stall_i && !hz;
            if (!bus.stall_i) begin
                m_mem_v   = m_ex_v;
                m_mem_rw  = m_ex_c[8];
                m_mem_mr  = m_ex_c[6];
                m_mem_mw  = m_ex_c[5];
                m_mem_mtr = m_ex_c[4];
                m_mem_rd  = m_ex_rd;
            end
            if (bus.flush_i || (!bus.stall_i && !acc)) begin
                m_ex_v = 0; m_ex_c = '0; m_ex_rd = '0;
            end else if (acc) begin
                m_ex_v = 1; m_ex_c = row[8:0]; m_ex_rd = bus.instr_i[11:7];
            end
            m_ill = acc && row[9];
            if (m_ill) m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("hazard",       bus.hazard_o,       model_hazard());
            check("ex_valid",     bus.ex_valid_o,     m_ex_v);
            check("ex_regwrite",  bus.ex_regwrite_o,  m_ex_c[8]);
            check("ex_alusrc",    bus.ex_alusrc_o,    m_ex_c[7]);
            check("ex_memread",   bus.ex_memread_o,   m_ex_c[6]);
            check("ex_memwrite",  bus.ex_memwrite_o,  m_ex_c[5]);
            check("ex_memtoreg",  bus.ex_memtoreg_o,  m_ex_c[4]);
            check("ex_branch",    bus.ex_branch_o,    m_ex_c[3]);
            check("ex_jump",      bus.ex_jump_o,      m_ex_c[2]);
            check("ex_aluop",     bus.ex_aluop_o,     {30'd0, m_ex_c[1:0]});
            check("ex_rd",        bus.ex_rd_o,        m_ex_rd);
            check("mem_valid",    bus.mem_valid_o,    m_mem_v);
            check("mem_regwrite", bus.mem_regwrite_o, m_mem_rw);
            check("mem_memread",  bus.mem_memread_o,  m_mem_mr);
            check("mem_memwrite", bus.mem_memwrite_o, m_mem_mw);
            check("mem_memtoreg", bus.mem_memtoreg_o, m_mem_mtr);
            check("mem_rd",       bus.mem_rd_o,       m_mem_rd);
            check("illegal",      bus.illegal_o,      m_ill);
            check("ill_cnt",      bus.ill_cnt_o,      m_cnt);
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [31:0] mk(input logic [6:0] opc, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'd0, rs2, rs1, 3'd0, rd, opc};
    endfunction

    task automatic apply(input logic [31:0] instr, input logic v, input logic st, input logic fl);
        bus.instr_i    = instr;
        bus.id_valid_i = v;
        bus.stall_i    = st;
        bus.flush_i    = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        apply(32'd0, 1'b0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
    endtask

    logic [6:0] op_pool [9];
    int pulses;

    initial begin
        op_pool = '{7'b0110011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b0010011,
                    7'b1101111, 7'b1100111, 7'b1111111, 7'b0000000};
        apply(32'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        tick();
        chk_en = 1'b1;
        rst = 1'b0;

        // Reset state
        check("rst_ex_valid", bus.ex_valid_o, 1'b0);
        check("rst_mem_valid", bus.mem_valid_o, 1'b0);
        check("rst_ill_cnt", bus.ill_cnt_o, 0);

        // R-type add x3,x1,x2
        apply(mk(7'b0110011, 5'd3, 5'd1, 5'd2), 1'b1, 1'b0, 1'b0);
        tick();
        check("add_ex_regwrite", bus.ex_regwrite_o, 1'b1);
        check("add_ex_aluop", bus.ex_aluop_o, 2'b10);
        check("add_ex_alusrc", bus.ex_alusrc_o, 1'b0);
        apply(32'd0, 1'b0, 1'b0, 1'b0);
        tick();
        check("add_mem_regwrite", bus.mem_regwrite_o, 1'b1);

        // ld x5 ; add x6,x5,x7 -> one hazard cycle, bubble, then the add
        apply(mk(7'b0000011, 5'd5, 5'd1, 5'd0), 1'b1, 1'b0, 1'b0);
        tick();
        apply(mk(7'b0110011, 5'd6, 5'd5, 5'd7), 1'b1, 1'b0, 1'b0);
        #1;
        check("lu_hazard_on", bus.hazard_o, 1'b1);
        tick();
        check("lu_bubble", bus.ex_valid_o, 1'b0);
        check("lu_hazard_off", bus.hazard_o, 1'b0);
        tick();
        check("lu_add_valid", bus.ex_valid_o, 1'b1);
        check("lu_add_rd", bus.ex_rd_o, 5'd6);

        // ld x0 ; use of x0 -> no hazard
        apply(mk(7'b0000011, 5'd0, 5'd1, 5'd0), 1'b1, 1'b0, 1'b0);
        tick();
        apply(mk(7'b0110011, 5'd1, 5'd0, 5'd0), 1'b1, 1'b0, 1'b0);
        #1;
        check("x0_no_hazard", bus.hazard_o, 1'b0);
        tick();

        // sd reaches EX/MEM, then flush+stall together
        apply(mk(7'b0100011, 5'd0, 5'd2, 5'd3), 1'b1, 1'b0, 1'b0);
        tick();
        apply(32'd0, 1'b0, 1'b0, 1'b0);
        tick();
        check("sd_in_mem", bus.mem_memwrite_o, 1'b1);
        apply(mk(7'b0110011, 5'd4, 5'd1, 5'd2), 1'b1, 1'b1, 1'b1);
        tick();
        check("fs_ex_cleared", bus.ex_valid_o, 1'b0);
        check("fs_mem_held", bus.mem_memwrite_o, 1'b1);

        // jal x1
        apply(32'd0, 1'b0, 1'b0, 1'b0);
        tick();
        apply(mk(7'b1101111, 5'd1, 5'd0, 5'd0), 1'b1, 1'b0, 1'b0);
        tick();
`ifdef PIPE_CONTROL_JUMP_EN
        check("jal_jump", bus.ex_jump_o, 1'b1);
        check("jal_regwrite", bus.ex_regwrite_o, 1'b1);
`else
        check("jal_illegal", bus.illegal_o, 1'b1);
        check("jal_regwrite", bus.ex_regwrite_o, 1'b0);
        check("jal_jump", bus.ex_jump_o, 1'b0);
        check("jal_aluop", bus.ex_aluop_o, 2'b00);
`endif

        // Stalled illegal is not counted; then 300 accepted illegals saturate
        do_reset();
        apply(mk(7'b1111111, 5'd1, 5'd0, 5'd0), 1'b1, 1'b1, 1'b0);
        tick();
        check("stall_ill_pulse", bus.illegal_o, 1'b0);
        check("stall_ill_cnt", bus.ill_cnt_o, 0);
        pulses = 0;
        for (int i = 0; i < 300; i++) begin
            apply(mk(7'b1111111, 5'd1, 5'd0, 5'd0), 1'b1, 1'b0, 1'b0);
            tick();
            if (bus.illegal_o === 1'b1) pulses++;
        end
        check("ill_pulses", pulses, 300);
        check("ill_cnt_sat", bus.ill_cnt_o, 255);
        apply(32'd0, 1'b0, 1'b0, 1'b0);
        tick();
        check("ill_pulse_end", bus.illegal_o, 1'b0);
        check("ill_cnt_hold", bus.ill_cnt_o, 255);

        // Randomised traffic with small register indices to provoke hazards
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] instr;
            instr = $urandom;
            if ($urandom_range(0, 9) != 0) instr[6:0] = op_pool[$urandom_range(0, 8)];
            instr[11:7]  = 5'($urandom_range(0, 3));
            instr[19:15] = 5'($urandom_range(0, 3));
            instr[24:20] = 5'($urandom_range(0, 3));
            rst = ($urandom_range(0, 99) == 0);
            apply(instr, ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 6) == 0));
            tick();
        end
        rst = 1'b0;
        apply(32'd0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pipe_control.md
PIPE_CONTROL -- requirements
Module: pipe_control

Interface
REQ-001 SHALL have parameter ALUOP_W, default 2, meaning ALU-op field width (min 2; upper bits zero-padded).
REQ-002 SHALL have parameter ILL_CNT_W, default 8, meaning illegal-instruction counter width.
REQ-003 SHALL have port clk_i  in  1  the single clock.
REQ-004 SHALL have port rst_i  in  1  reset, synchronous and active-high.
REQ-005 SHALL have port instr_i  in  32  instruction in ID; opcode [6:0], rd [11:7], rs1 [19:15], rs2 [24:20].
REQ-006 SHALL have port id_valid_i  in  1  instr_i holds a real instruction.
REQ-007 SHALL have port stall_i  in  1  hold all stage registers.
REQ-008 SHALL have port flush_i  in  1  taken branch; kill the ID instruction.
REQ-009 SHALL have port hazard_o  out  1  load-use hazard; hold PC and IF/ID.
REQ-010 SHALL have ports ex_valid_o, ex_regwrite_o, ex_memread_o, ex_memwrite_o, ex_memtoreg_o, ex_branch_o, ex_alusrc_o, ex_jump_o  out  1 each, plus ex_aluop_o  out  ALUOP_W and ex_rd_o  out  5, all forming the ID/EX control register.
REQ-011 SHALL have ports mem_valid_o, mem_regwrite_o, mem_memread_o, mem_memwrite_o, mem_memtoreg_o  out  1 each, plus mem_rd_o  out  5, all forming the EX/MEM control register.
REQ-012 SHALL have port illegal_o  out  1  registered one-cycle pulse on an accepted illegal opcode.
REQ-013 SHALL have port ill_cnt_o  out  ILL_CNT_W  saturating count of accepted illegal opcodes.

Function
REQ-014 SHALL decode opcodes as follows; fields are RegWrite, ALUSrc, MemRead, MemWrite, MemtoReg, Branch, aluop.
- 0110011 (R): 1, 0, 0, 0, 0, 0, 10.
- 0000011 (ld): 1, 1, 1, 0, 1, 0, 00.
- 0100011 (sd): 0, 1, 0, 1, 0, 0, 00.
- 1100011 (beq): 0, 0, 0, 0, 0, 1, 01.
- 0010011 (I): 1, 1, 0, 0, 0, 0, 11.
REQ-015 SHALL treat any other opcode as illegal and decode it to all-zero controls; no X values are ever driven.
REQ-016 SHALL drive hazard_o combinationally as id_valid_i & ex_valid_o & ex_memread_o & (ex_rd_o!=0) & (ex_rd_o==rs1 | (ex_rd_o==rs2 & opcode in {R, sd, beq})) & ~flush_i.
REQ-017 SHALL update ID/EX each clock with priority rst_i > flush_i > stall_i > hazard_o > normal load.
- flush: load a bubble (valid 0, all controls 0, rd 0).
- stall: hold.
- hazard: load a bubble.
- normal: load the decoded controls, with valid = id_valid_i and rd = instr_i[11:7].
REQ-018 SHALL load a bubble on normal load when id_valid_i=0, i.e. all controls are zero whenever valid=0.
REQ-019 SHALL update EX/MEM as follows: hold when stall_i=1, otherwise copy the corresponding ID/EX fields; flush_i does not affect EX/MEM.
REQ-020 SHALL, when flush_i and stall_i are both 1, clear ID/EX and hold EX/MEM.
REQ-021 SHALL accept an instruction only on a normal load with id_valid_i=1.
REQ-022 SHALL, on an accepted illegal opcode, pulse illegal_o for exactly one cycle on the next cycle and increment ill_cnt_o.
REQ-023 SHALL saturate ill_cnt_o at all-ones; it never wraps.
REQ-024 SHALL give a control latency of 1 cycle from ID to ex_*, and 2 cycles to mem_*.

Reset
REQ-025 SHALL, while rst_i is high at a clock edge, clear every registered output to 0 (valid, controls, rd, illegal_o, ill_cnt_o).
REQ-026 SHALL let reset mid-stall or mid-hazard discard the held state; the first post-reset cycle behaves as a normal load.

Configuration
REQ-027 SHALL, with PIPE_CONTROL_JUMP_EN defined, additionally decode:
- 1101111 (jal) as RegWrite 1, ALUSrc 0, jump 1, aluop 00, all others 0.
- 1100111 (jalr) as RegWrite 1, ALUSrc 1, jump 1, aluop 00, all others 0.
REQ-028 SHALL, without PIPE_CONTROL_JUMP_EN, treat jal and jalr as illegal and tie ex_jump_o to 0.

Structure
REQ-029 SHALL place in shared package pipe_ctrl_pkg:
- the opcode constants;
- the ALU-op encodings (ADD=00, BRANCH=01, RFUNC=10, IFUNC=11);
- the control-bundle struct typedef;
- the bubble constant.
REQ-030 SHALL put decoding in one combinational sub-module, ctrl_decode (opcode -> bundle + illegal flag), instantiated once.

Verification
REQ-031 SHALL cover: R-type add with id_valid_i=1 -> next cycle ex_regwrite_o=1, ex_aluop_o=10, ex_alusrc_o=0; the cycle after, mem_regwrite_o=1.
REQ-032 SHALL cover: ld x5 followed by add x6,x5,x7 -> hazard_o=1 for one cycle, a bubble appears in ID/EX (ex_valid_o=0), then the add loads.
REQ-033 SHALL cover: ld x0 followed by a use of x0 -> hazard_o stays 0.
REQ-034 SHALL cover: flush_i=1 together with stall_i=1 while EX/MEM holds sd -> ex_valid_o=0 and mem_memwrite_o stays 1.
REQ-035 SHALL cover: 300 accepted opcodes 1111111 with ILL_CNT_W=8 -> ill_cnt_o=255, illegal_o pulses once per accept, and a stalled illegal opcode is not counted.
REQ-036 SHALL cover: jal with PIPE_CONTROL_JUMP_EN -> ex_jump_o=1 and ex_regwrite_o=1; without the macro -> illegal_o=1 and all controls 0.
